// File: rtl/pipe_pkg.sv
// Shared pipeline constants: hazard FSM state codes, the canonical NOP and
// a width helper for small saturating counters.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all ones. Clear together with increment loads 1,
// so a sequence can be started and its first cycle counted on the same edge.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)                        cnt_d = i_inc ? W'(1) : '0;
    else if (i_inc && (cnt_q != '1))  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use, taken branch, data
// memory wait and fence drain, with saturating perf counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int CNT_W     = 32,
  parameter int DRAIN_CYC = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_use_rs1,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_memRead,
  input  logic              i_ex_branch_taken,
  input  logic              i_mem_req,
  input  logic              i_mem_ready,
  input  logic              i_drain_req,
  output logic              o_pc_hold,
  output logic              o_ifid_hold,
  output logic              o_ifid_flush,
  output logic              o_idex_bubble,
  output logic              o_stall_front,
  output logic              o_memwb_bubble,
  output logic              o_drain_done,
  output logic              o_mem_timeout,
  output logic [1:0]        o_state,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  localparam int WAIT_W  = cnt_w(TIMEOUT);
  localparam int DRAIN_W = cnt_w(DRAIN_CYC);

  logic [1:0]         state_q, state_d;
  logic               pend_q, pend_d;
  logic               tmo_q, tmo_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [DRAIN_W-1:0] drain_q;

  logic lu_hazard, mem_stall;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble, stall_front, memwb_bubble;
  logic drain_done, flush_inc, drain_go, drain_step;

  assign lu_hazard = i_ex_memRead && (i_ex_rd != '0) &&
                     ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                      (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

  // Once waiting, only ready releases the freeze; elsewhere a new request must be present.
  assign mem_stall = (state_q == S_MEM_WAIT) ? !i_mem_ready : (i_mem_req && !i_mem_ready);

  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    stall_front  = 1'b0;
    memwb_bubble = 1'b0;
    drain_done   = 1'b0;
    flush_inc    = 1'b0;
    drain_go     = 1'b0;
    drain_step   = 1'b0;
    state_d      = state_q;
    pend_d       = pend_q;

    if (mem_stall) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b1;
      stall_front  = 1'b1;
      memwb_bubble = 1'b1;
    end

    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d = S_MEM_WAIT;
          pend_d  = pend_q | i_drain_req;
        end else if (i_ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_inc   = 1'b1;
          pend_d      = pend_q | i_drain_req;
        end else if (lu_hazard) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          pend_d      = pend_q | i_drain_req;
        end else if (i_drain_req || pend_q) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          drain_go    = 1'b1;
          pend_d      = 1'b0;
          state_d     = S_DRAIN;
        end
      end
      S_MEM_WAIT: begin
        pend_d = pend_q | i_drain_req;
        if (!mem_stall) state_d = S_RUN;
      end
      S_DRAIN: begin
        // A memory stall freezes the drain; the bubble count resumes afterwards.
        if (!mem_stall) begin
          pc_hold     = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          if (drain_q == DRAIN_W'(DRAIN_CYC)) begin
            drain_done = 1'b1;
            state_d    = S_RUN;
          end else begin
            drain_step = 1'b1;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign tmo_d = tmo_q | (mem_stall && (wait_q == WAIT_W'(TIMEOUT - 1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RUN;
      pend_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tmo_q   <= tmo_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(pc_hold), .i_clr(1'b0), .o_q(o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(flush_inc), .i_clr(1'b0), .o_q(o_flush_cnt)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(mem_stall), .i_clr(!mem_stall), .o_q(wait_q)
  );

  sat_counter #(.W(DRAIN_W)) u_drain_cnt (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(drain_go | drain_step),
    .i_clr(state_q != S_DRAIN), .o_q(drain_q)
  );

  // Control strobes are forced low while reset is asserted.
  assign o_pc_hold      = i_rst_n & pc_hold;
  assign o_ifid_hold    = i_rst_n & ifid_hold;
  assign o_ifid_flush   = i_rst_n & ifid_flush;
  assign o_idex_bubble  = i_rst_n & idex_bubble;
  assign o_stall_front  = i_rst_n & stall_front;
  assign o_memwb_bubble = i_rst_n & memwb_bubble;
  assign o_drain_done   = i_rst_n & drain_done;
  assign o_mem_timeout  = tmo_q;
  assign o_state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus random traffic for hazard_ctrl, every cycle checked
// against a cycle-level behavioural model of the stall/flush rules.
module tb_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 6;
  localparam int DC   = 3;
  localparam int TO   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [AW-1:0] i_id_rs1, i_id_rs2, i_ex_rd;
  logic          i_id_use_rs1, i_id_use_rs2, i_ex_memRead, i_ex_branch_taken;
  logic          i_mem_req, i_mem_ready, i_drain_req;
  logic          o_pc_hold, o_ifid_hold, o_ifid_flush, o_idex_bubble;
  logic          o_stall_front, o_memwb_bubble, o_drain_done, o_mem_timeout;
  logic [1:0]    o_state;
  logic [CW-1:0] o_stall_cnt, o_flush_cnt;

  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .DRAIN_CYC(DC), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_ex_rd(i_ex_rd), .i_ex_memRead(i_ex_memRead),
    .i_ex_branch_taken(i_ex_branch_taken),
    .i_mem_req(i_mem_req), .i_mem_ready(i_mem_ready), .i_drain_req(i_drain_req),
    .o_pc_hold(o_pc_hold), .o_ifid_hold(o_ifid_hold), .o_ifid_flush(o_ifid_flush),
    .o_idex_bubble(o_idex_bubble), .o_stall_front(o_stall_front),
    .o_memwb_bubble(o_memwb_bubble), .o_drain_done(o_drain_done),
    .o_mem_timeout(o_mem_timeout), .o_state(o_state),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: mode 0 run / 1 waiting on memory / 2 draining.
  int m_mode, m_run, m_left, m_stalls, m_flushes, n_mode, n_run, n_left, n_stalls, n_flushes;
  bit m_pend, m_to, n_pend, n_to;
  bit e_pc, e_ifh, e_iff, e_idb, e_sf, e_mwb, e_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int satc(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic idle();
    i_id_rs1 = '0; i_id_rs2 = '0; i_ex_rd = '0;
    i_id_use_rs1 = 0; i_id_use_rs2 = 0; i_ex_memRead = 0; i_ex_branch_taken = 0;
    i_mem_req = 0; i_mem_ready = 0; i_drain_req = 0;
  endtask

  task automatic m_reset();
    m_mode = 0; m_run = 0; m_left = 0; m_stalls = 0; m_flushes = 0; m_pend = 0; m_to = 0;
  endtask

  task automatic eval();
    bit stall, lu, frz3;
    lu = i_ex_memRead && (i_ex_rd != 0) &&
         ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) || (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
    stall = (m_mode == 1) ? !i_mem_ready : (i_mem_req && !i_mem_ready);
    frz3 = 0;
    {e_pc, e_ifh, e_iff, e_idb, e_sf, e_mwb, e_done} = '0;
    n_mode = m_mode; n_pend = m_pend; n_left = m_left; n_flushes = m_flushes;
    if (stall) {e_pc, e_ifh, e_sf, e_mwb} = 4'hf;
    if (m_mode == 0) begin
      if (stall) n_mode = 1;
      else if (i_ex_branch_taken) begin e_iff = 1; e_idb = 1; n_flushes++; end
      else if (lu) frz3 = 1;
      else if (i_drain_req || m_pend) begin frz3 = 1; n_mode = 2; n_left = DC - 1; end
      if (n_mode == 2) n_pend = 0;
      else if (i_drain_req) n_pend = 1;
    end else if (m_mode == 1) begin
      if (i_drain_req) n_pend = 1;
      if (!stall) n_mode = 0;
    end else if (!stall) begin
      frz3 = 1;
      if (m_left == 0) begin e_done = 1; n_mode = 0; end
      else n_left = m_left - 1;
    end
    if (frz3) begin e_pc = 1; e_ifh = 1; e_idb = 1; end
    n_stalls = m_stalls + int'(e_pc);
    n_run = stall ? m_run + 1 : 0;
    n_to = m_to || (n_run >= TO);
  endtask

  task automatic chk_all();
    chk("pc_hold", o_pc_hold, e_pc);
    chk("ifid_hold", o_ifid_hold, e_ifh);
    chk("ifid_flush", o_ifid_flush, e_iff);
    chk("idex_bubble", o_idex_bubble, e_idb);
    chk("stall_front", o_stall_front, e_sf);
    chk("memwb_bubble", o_memwb_bubble, e_mwb);
    chk("drain_done", o_drain_done, e_done);
    chk("mem_timeout", o_mem_timeout, m_to);
    chk("state", o_state, m_mode);
    chk("stall_cnt", o_stall_cnt, satc(m_stalls));
    chk("flush_cnt", o_flush_cnt, satc(m_flushes));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic cyc();
    #2;
    eval();
    chk_all();
    @(posedge i_clk);
    m_mode = n_mode; m_run = n_run; m_left = n_left; m_pend = n_pend; m_to = n_to;
    m_stalls = n_stalls; m_flushes = n_flushes;
    @(negedge i_clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " outs"}, {o_pc_hold, o_ifid_hold, o_ifid_flush, o_idex_bubble, o_stall_front,
                         o_memwb_bubble, o_drain_done, o_mem_timeout}, 0);
    chk({tag, " state"}, o_state, 0);
    chk({tag, " stall_cnt"}, o_stall_cnt, 0);
    chk({tag, " flush_cnt"}, o_flush_cnt, 0);
  endtask

  task automatic do_reset();
    i_rst_n = 0;
    m_reset();
    #2 chk_zero("rst");
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  int n1, n2, dn, dpos, first;

  initial begin
    idle();
    m_reset();
    @(negedge i_clk);
    i_mem_req = 1;
    #1 chk_zero("reset");
    idle();
    @(negedge i_clk);
    i_rst_n = 1;

    // load-use: ld x5 in EX, add x6,x5,x1 in ID
    i_ex_memRead = 1; i_ex_rd = 5; i_id_rs1 = 5; i_id_use_rs1 = 1; i_id_rs2 = 1; i_id_use_rs2 = 1;
    cyc();
    idle();
    cyc();
    chk("lu stall_cnt", o_stall_cnt, 1);
    i_ex_memRead = 1; i_ex_rd = 0; i_id_rs1 = 0; i_id_use_rs1 = 1;
    cyc();
    chk("lu rd0 stall_cnt", o_stall_cnt, 1);

    // taken branch beats a simultaneous load-use
    i_ex_rd = 5; i_id_rs1 = 5; i_ex_branch_taken = 1;
    #1;
    chk("br pc_hold", o_pc_hold, 0);
    chk("br flush", o_ifid_flush, 1);
    chk("br bubble", o_idex_bubble, 1);
    cyc();
    chk("br flush_cnt", o_flush_cnt, 1);
    idle();
    cyc();

    // four-cycle memory wait
    do_reset();
    n1 = 0;
    i_mem_req = 1;
    for (int k = 0; k < 5; k++) begin
      i_mem_ready = (k == 4);
      #1 if (o_state == 2'd1) n1++;
      cyc();
    end
    idle();
    chk("wait state1 cycles", n1, 4);
    chk("wait stall_cnt", o_stall_cnt, 4);
    chk("wait back to run", o_state, 0);

    // timeout: rises on the 8th MEM_WAIT cycle, sticky until reset
    do_reset();
    n1 = 0; first = 0;
    i_mem_req = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (o_state == 2'd1) n1++;
      if (first == 0 && o_mem_timeout) first = n1;
      cyc();
    end
    chk("timeout rise", first, 8);
    i_mem_ready = 1;
    cyc();
    idle();
    cyc();
    cyc();
    chk("timeout sticky", o_mem_timeout, 1);
    do_reset();
    chk("timeout cleared", o_mem_timeout, 0);

    // plain drain
    i_drain_req = 1;
    cyc();
    idle();
    n2 = 0; dn = 0; dpos = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (o_state == 2'd2) n2++;
      if (o_drain_done) begin dn++; dpos = n2; end
      cyc();
    end
    chk("drain cycles", n2, 3);
    chk("drain done count", dn, 1);
    chk("drain done pos", dpos, 3);

    // drain with a 2-cycle memory stall in the middle
    i_drain_req = 1;
    cyc();
    n2 = 0; dn = 0;
    for (int k = 1; k <= 10; k++) begin
      idle();
      if (k == 2 || k == 3) i_mem_req = 1;
      #1;
      if (o_state == 2'd2) n2++;
      if (o_drain_done) dn++;
      cyc();
    end
    chk("drain+stall cycles", n2, 5);
    chk("drain+stall done", dn, 1);

    // asynchronous reset in the middle of a memory wait
    idle();
    i_mem_req = 1;
    cyc(); cyc(); cyc();
    chk("pre-rst state", o_state, 1);
    #2 i_rst_n = 0;
    m_reset();
    #1 chk_zero("async rst");
    @(negedge i_clk);
    idle();
    i_rst_n = 1;
    #1;
    chk("post-rst state", o_state, 0);
    chk("post-rst stall_cnt", o_stall_cnt, 0);
    cyc();

    // random traffic; counters saturate along the way
    for (int k = 0; k < 3000; k++) begin
      i_id_rs1          = AW'($urandom_range(0, 3));
      i_id_rs2          = AW'($urandom_range(0, 3));
      i_ex_rd           = AW'($urandom_range(0, 3));
      i_id_use_rs1      = ($urandom_range(0, 1) == 1);
      i_id_use_rs2      = ($urandom_range(0, 1) == 1);
      i_ex_memRead      = ($urandom_range(0, 9) < 4);
      i_ex_branch_taken = ($urandom_range(0, 9) < 2);
      i_mem_req         = ($urandom_range(0, 9) < 3);
      i_mem_ready       = ($urandom_range(0, 9) < 5);
      i_drain_req       = ($urandom_range(0, 9) < 1);
      cyc();
    end
    chk("rand stall_cnt saturated", o_stall_cnt, CMAX);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
